// File: rtl/findmax_pkg.sv
// Shared types and constants for the find-max sample source.
// Provides the source FSM state enum, default width and LFSR tap lookup.
package findmax_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } src_state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_MAX_LEN = 16;

    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

    // Galois tap masks for the supported widths; other widths fall
    // back to the 8-bit mask and are not maximal-length.
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            8:       return {24'h0, LFSR_TAPS_8};
            16:      return {16'h0, LFSR_TAPS_16};
            32:      return 32'h8020_0003;
            default: return {24'h0, LFSR_TAPS_8};
        endcase
    endfunction

endpackage

// File: rtl/findmax_lfsr.sv
// Galois LFSR: loads a seed (zero replaced by 1) and steps on advance.
// Ports: clk, reset (async high), load, seed, advance, value.
module findmax_lfsr
    import findmax_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             advance,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            // An all-zero state would lock up, so substitute 1.
            lfsr_d = (seed == '0) ? WIDTH'(1) : seed;
        end else if (advance) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/findmax_ucmp.sv
// Unsigned magnitude comparator shared by the find-max datapath.
// Ports: a, b (WIDTH), gt = (a > b) unsigned.
module findmax_ucmp
    import findmax_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt
);

    assign gt = (a > b);

endmodule

// File: rtl/findmax_stream_gen.sv
// Pseudo-random burst source on a valid/ready stream with last flag.
// Ports: clk, reset, start, seed, len, out_data/valid/ready/last, busy,
// done; exp_max (running max) only when FINDMAX_SRC_EXPMAX_EN is defined.
module findmax_stream_gen
    import findmax_pkg::*;
#(
    parameter  int WIDTH   = DEFAULT_WIDTH,
    parameter  int MAX_LEN = DEFAULT_MAX_LEN,
    localparam int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [LW-1:0]    len,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
`ifdef FINDMAX_SRC_EXPMAX_EN
    ,
    output logic [WIDTH-1:0] exp_max
`endif
);

    src_state_t       state_q, state_d;
    logic [LW-1:0]    count_q, count_d;
    logic [LW-1:0]    len_q, len_d;
    logic             load;
    logic             xfer;
    logic             is_last;
    logic [WIDTH-1:0] lfsr_value;

    assign xfer    = (state_q == SEND) && out_ready;
    assign is_last = (count_q == len_q - LW'(1));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        load    = 1'b1;
                        len_d   = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
                        count_d = '0;
                        state_d = SEND;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SEND: begin
                if (xfer) begin
                    // Count stops at len_q-1; the last beat leaves SEND.
                    if (is_last) begin
                        state_d = DONE;
                    end else begin
                        count_d = count_q + LW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    findmax_lfsr #(
        .WIDTH (WIDTH)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .seed    (seed),
        .advance (xfer),
        .value   (lfsr_value)
    );

    assign out_valid = (state_q == SEND);
    assign out_data  = out_valid ? lfsr_value : '0;
    assign out_last  = out_valid && is_last;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

`ifdef FINDMAX_SRC_EXPMAX_EN
    logic [WIDTH-1:0] exp_max_q, exp_max_d;
    logic             data_gt;

    findmax_ucmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a  (lfsr_value),
        .b  (exp_max_q),
        .gt (data_gt)
    );

    always_comb begin
        exp_max_d = exp_max_q;
        if (state_q == IDLE && start) begin
            exp_max_d = '0;
        end else if (xfer && data_gt) begin
            exp_max_d = lfsr_value;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_max_q <= '0;
        end else begin
            exp_max_q <= exp_max_d;
        end
    end

    assign exp_max = exp_max_q;
`endif

endmodule

// File: tb/tb_findmax_stream_gen.sv
// Randomized self-checking bench for findmax_stream_gen.
// Expected beats come from a plain LFSR sequence model per burst.
module tb_findmax_stream_gen;

    localparam int WIDTH = 8;
    localparam int MAX_LEN = 16;
    localparam int LW = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] seed_i;
    logic [LW-1:0]    len_i;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic             done;
`ifdef FINDMAX_SRC_EXPMAX_EN
    logic [WIDTH-1:0] exp_max;
`endif

    int checks = 0;
    int failures = 0;
    logic [WIDTH-1:0] obs[$];

    always #5 clk = ~clk;

    findmax_stream_gen #(
        .WIDTH   (WIDTH),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .start     (start),
        .seed      (seed_i),
        .len       (len_i),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
`ifdef FINDMAX_SRC_EXPMAX_EN
        ,
        .exp_max   (exp_max)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
        end
    endtask

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] l);
        return (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
    endfunction

    // mode 0: ready high; 1: random ready + stray start pulses;
    // 2: ready low for 3 cycles while beat index 2 is presented.
    task automatic burst(input logic [WIDTH-1:0] sd, input logic [LW-1:0] ln,
                         input int mode, output int cyc);
        logic [WIDTH-1:0] beats[$];
        logic [WIDTH-1:0] l;
        logic [WIDTH-1:0] run_max;
        logic [WIDTH-1:0] mx;
        int n;
        int idx;
        int stall;
        logic rdy;
        n = (int'(ln) > MAX_LEN) ? MAX_LEN : int'(ln);
        l = (sd == 0) ? 8'h01 : sd;
        mx = 0;
        for (int i = 0; i < n; i++) begin
            beats.push_back(l);
            if (l > mx) mx = l;
            l = lfsr_next(l);
        end
        obs.delete();
        start = 1'b1;
        seed_i = sd;
        len_i = ln;
        @(negedge clk);
        start = 1'b0;
        seed_i = WIDTH'($urandom);
        len_i = LW'($urandom);
        cyc = 0;
        idx = 0;
        stall = 0;
        run_max = 0;
        while (idx < n && cyc < 400) begin
            chk("valid", 32'(out_valid), 32'd1);
            chk("busy", 32'(busy), 32'd1);
            chk("done_in_send", 32'(done), 32'd0);
            chk("data", 32'(out_data), 32'(beats[idx]));
            chk("last", 32'(out_last), 32'(idx == n - 1));
`ifdef FINDMAX_SRC_EXPMAX_EN
            chk("exp_max_run", 32'(exp_max), 32'(run_max));
`endif
            start = 1'b0;
            case (mode)
                1: begin
                    rdy = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 5) == 0) begin
                        start = 1'b1;
                        seed_i = WIDTH'($urandom);
                        len_i = LW'($urandom);
                    end
                end
                2: begin
                    rdy = !(idx == 2 && stall < 3);
                    if (!rdy) stall++;
                end
                default: rdy = 1'b1;
            endcase
            out_ready = rdy;
            if (rdy) obs.push_back(out_data);
            @(negedge clk);
            cyc++;
            if (rdy) begin
                if (beats[idx] > run_max) run_max = beats[idx];
                idx++;
            end
        end
        start = 1'b0;
        chk("burst_timeout", 32'(idx), 32'(n));
        out_ready = 1'($urandom);
        chk("done_pulse", 32'(done), 32'd1);
        chk("valid_in_done", 32'(out_valid), 32'd0);
        chk("busy_in_done", 32'(busy), 32'd1);
`ifdef FINDMAX_SRC_EXPMAX_EN
        chk("exp_max_done", 32'(exp_max), 32'(mx));
`endif
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("valid_idle", 32'(out_valid), 32'd0);
        chk("data_gated", 32'(out_data), 32'd0);
`ifdef FINDMAX_SRC_EXPMAX_EN
        chk("exp_max_hold", 32'(exp_max), 32'(mx));
`endif
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        start = 1'b0;
        seed_i = '0;
        len_i = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
`ifdef FINDMAX_SRC_EXPMAX_EN
        chk("rst_exp_max", 32'(exp_max), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        burst(8'h01, 5'd4, 0, cyc);
        chk("b1_n", 32'(obs.size()), 32'd4);
        if (obs.size() == 4) begin
            chk("b1_beat0", 32'(obs[0]), 32'h01);
            chk("b1_beat1", 32'(obs[1]), 32'hB8);
            chk("b1_beat2", 32'(obs[2]), 32'h5C);
            chk("b1_beat3", 32'(obs[3]), 32'h2E);
        end
        chk("b1_cycles", 32'(cyc), 32'd4);

        burst(8'h01, 5'd4, 2, cyc);
        chk("stall_cycles", 32'(cyc), 32'd7);
        if (obs.size() == 4) begin
            chk("stall_beat2", 32'(obs[2]), 32'h5C);
            chk("stall_beat3", 32'(obs[3]), 32'h2E);
        end

        burst(8'h00, 5'd2, 0, cyc);
        chk("seed0_n", 32'(obs.size()), 32'd2);
        if (obs.size() == 2) begin
            chk("seed0_beat0", 32'(obs[0]), 32'h01);
            chk("seed0_beat1", 32'(obs[1]), 32'hB8);
        end

        burst(8'h5A, 5'd0, 0, cyc);
        chk("len0_cycles", 32'(cyc), 32'd0);

        burst(8'h33, 5'd31, 0, cyc);
        chk("clamp_n", 32'(obs.size()), 32'd16);

        burst(8'h01, 5'd4, 1, cyc);
        chk("midstart_n", 32'(obs.size()), 32'd4);

        // Asynchronous abort after two beats.
        start = 1'b1;
        seed_i = 8'h01;
        len_i = 5'd4;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_abort_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_last", 32'(out_last), 32'd0);
`ifdef FINDMAX_SRC_EXPMAX_EN
        chk("abort_exp_max", 32'(exp_max), 32'd0);
`endif
        @(negedge clk);
        chk("abort_no_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_done2", 32'(done), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);

        burst(8'h01, 5'd4, 0, cyc);
        if (obs.size() == 4) begin
            chk("replay_beat0", 32'(obs[0]), 32'h01);
            chk("replay_beat3", 32'(obs[3]), 32'h2E);
        end

        for (int k = 0; k < 25; k++) begin
            burst(WIDTH'($urandom), LW'($urandom_range(0, 31)), 1, cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/findmax_stream_gen.md
# findmax_stream_gen

Pseudo-random sample source that drives the input side of the find-max FSM datapath. On `start` it emits a burst of `len` WIDTH-bit unsigned samples from a Galois LFSR over a valid/ready stream and flags the final beat. It is the producer end of the sample stream the find-max FSM consumes, used both on the board and as the bench stimulus source.

## Interface
- `WIDTH`, 8, sample width in bits (LFSR width).
- `MAX_LEN`, 16, maximum burst length; `LW = $clog2(MAX_LEN+1)`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  burst request; sampled only in IDLE.
- `seed`  in  WIDTH  LFSR seed, captured with `start`.
- `len`  in  LW  beats in the burst, captured with `start`.
- `out_data`  out  WIDTH  current sample.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the beat.
- `out_last`  out  1  current beat is the final beat of the burst.
- `busy`  out  1  high in SEND and DONE.
- `done`  out  1  one-cycle pulse at burst end.
- `exp_max`  out  WIDTH  only with `FINDMAX_SRC_EXPMAX_EN`; see Configuration.

## Operation
- States: IDLE, SEND, DONE.
- IDLE:
  - `start=1`, `len!=0`: capture `seed` into the LFSR and `min(len, MAX_LEN)` into the length register, clear the beat counter, go to SEND.
  - `start=1`, `len==0`: go directly to DONE; no beats are emitted.
- Seed of 0 is replaced by `WIDTH'h1` to avoid LFSR lock-up.
- SEND:
  - `out_valid=1`, `out_data=lfsr`, `out_last=1` when `count == len_r-1`.
  - A transfer is `out_valid && out_ready`. On a transfer: increment `count` and advance the LFSR with `next = (l >> 1) ^ (l[0] ? TAPS : 0)`.
  - A transfer with `out_last` goes to DONE.
- DONE: `done=1` for exactly one cycle, then go to IDLE.
- `start` is ignored outside IDLE.
- `seed` and `len` are not re-sampled mid-burst.
- Backpressure: while `out_valid && !out_ready`, `out_data` and `out_last` hold stable and the LFSR does not advance.
- `count` is LW bits wide and never exceeds `len_r-1`, so no wrap-around.
- Reset values: state IDLE; `out_valid`, `out_last`, `busy`, `done` all 0; `out_data` 0 (gated while not valid); `exp_max` 0.
- Reset asserted mid-burst aborts it asynchronously. `out_valid` drops without an `out_last` beat and `done` does not pulse.

## Timing
- `start` accepted at edge N: `out_valid=1` from cycle N+1.
- With `out_ready` held high: one beat per cycle; last beat at cycle N+len.
- `done` is high in the cycle after the last transfer.
- IDLE is re-entered one cycle later, so the next `start` can be accepted 2 cycles after the last transfer.
- `len==0`: `done` is high in cycle N+1.
- Outputs are registered or decoded from state only; there is no combinational path from `out_ready` to `out_valid`.

## Configuration
- Macro: `FINDMAX_SRC_EXPMAX_EN`.
- Defined:
  - Port `exp_max` exists.
  - Cleared to 0 when a burst starts.
  - On every transfer it is updated to `out_data` if `out_data > exp_max` (unsigned).
  - Final value is valid and stable from the `done` cycle until the next `start`, giving the bench a golden maximum.
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package `findmax_pkg`:
  - state enum `src_state_t` (IDLE, SEND, DONE);
  - `LFSR_TAPS` constant per WIDTH (8: `8'hB8`, 16: `16'hB400`);
  - default WIDTH constant.
- Sub-module `findmax_lfsr`:
  - ports: `clk`, `reset`, `load`, `seed`, `advance`, `value`;
  - owns the seed-zero substitution and the tap logic.
- The `exp_max` update reuses the existing unsigned comparator module.

## Test plan
- `seed=8'h01`, `len=4`, `out_ready=1`: beats 01, B8, 5C, 2E on consecutive cycles; `out_last` only on 2E; `done` the next cycle; `exp_max=8'hB8`.
- Same burst, `out_ready` low for 3 cycles on beat 2: 5C held stable with `out_valid=1`; sequence unchanged; total 7 cycles from start to `done`.
- `seed=0`, `len=2`: beats 01, B8.
- `len=0`: `done` one cycle after `start`; `out_valid` never asserts.
- `len=31` with `MAX_LEN=16`: exactly 16 beats.
- `start` pulsed mid-burst: ignored, sequence unchanged.
- `reset` asserted after beat 2 of a `len=4` burst: `out_valid`, `busy` and `exp_max` go to 0 asynchronously with no `done`; a fresh `start` (`seed=01`, `len=4`) replays the sequence from 01.
